// File: rtl/weight_stream_loader.sv
// weight_stream_loader
//   AXI4-Lite write master that drains a 16-bit weight stream into consecutive
//   word addresses (base_addr + 4*i). Each weight is one single-beat write.
//   It reports busy, a one-cycle done pulse, a sticky err_code and words_done.
//
// Optional feature: define WSL_READBACK_VERIFY_EN to read every word back after
//   an OKAY write response and compare it with the weight that was written.
//   When the macro is undefined, the AR/R channel outputs are tied to 0.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, base_addr, count    load request; sampled only while idle
//   busy, done, err_code       status (err: 00 ok, 01 bresp, 10 verify, 11 config)
//   words_done                 weights written (and verified) in the current load
//   s_wdata/s_valid/s_ready    weight stream input
//   m_axi_aw*/w*/b*            AXI4-Lite write channels
//   m_axi_ar*/r*               AXI4-Lite read channels (used only for verify)
module weight_stream_loader #(
  parameter int NUM_SYNAPSES = 219,
  parameter int CNT_W        = $clog2(NUM_SYNAPSES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] words_done,
  input  logic [15:0]      s_wdata,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [31:0]      m_axi_awaddr,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_wdata,
  output logic [3:0]       m_axi_wstrb,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  input  logic [1:0]       m_axi_bresp,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready,
  output logic [31:0]      m_axi_araddr,
  output logic             m_axi_arvalid,
  input  logic             m_axi_arready,
  input  logic [31:0]      m_axi_rdata,
  input  logic [1:0]       m_axi_rresp,
  input  logic             m_axi_rvalid,
  output logic             m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WRITE, S_RESP, S_RD_ADDR, S_RD_DATA, S_FINISH
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      base_lat;
  logic [CNT_W-1:0] cnt_lat;
  logic [CNT_W:0]   wd_inc;
  logic             last;
  logic             cfg_bad;
  logic             aw_ok, w_ok;

  assign cfg_bad = (count > CNT_W'(NUM_SYNAPSES)) || (base_addr[1:0] != 2'b00);
  // one extra bit so words_done+1 never wraps in the compare
  assign wd_inc  = {1'b0, words_done} + {{CNT_W{1'b0}}, 1'b1};
  assign last    = wd_inc >= {1'b0, cnt_lat};
  // a channel is finished once its valid is low or is being accepted now
  assign aw_ok   = !m_axi_awvalid || m_axi_awready;
  assign w_ok    = !m_axi_wvalid  || m_axi_wready;

  assign busy        = (state != S_IDLE) && (state != S_FINISH);
  assign done        = (state == S_FINISH);
  assign s_ready     = (state == S_FETCH);
  assign m_axi_wstrb = 4'b0011;

`ifdef WSL_READBACK_VERIFY_EN
  logic [15:0] weight;
  logic        rd_bad;
  logic        unused_ok;
  assign rd_bad    = (m_axi_rresp != 2'b00) || (m_axi_rdata[15:0] != weight);
  assign unused_ok = ^m_axi_rdata[31:16];
`else
  logic unused_ok;
  assign unused_ok     = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
  assign m_axi_araddr  = 32'h0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (count == '0 || cfg_bad) ? S_FINISH : S_FETCH;
      S_FETCH: if (s_valid) state_nxt = S_WRITE;
      S_WRITE: if (aw_ok && w_ok) state_nxt = S_RESP;
      S_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) state_nxt = S_FINISH;
`ifdef WSL_READBACK_VERIFY_EN
          else                      state_nxt = S_RD_ADDR;
`else
          else                      state_nxt = last ? S_FINISH : S_FETCH;
`endif
        end
      end
`ifdef WSL_READBACK_VERIFY_EN
      S_RD_ADDR: if (m_axi_arready) state_nxt = S_RD_DATA;
      S_RD_DATA: begin
        if (m_axi_rvalid) state_nxt = (rd_bad || last) ? S_FINISH : S_FETCH;
      end
`endif
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_lat      <= '0;
      cnt_lat       <= '0;
      err_code      <= 2'b00;
      words_done    <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
`ifdef WSL_READBACK_VERIFY_EN
      weight        <= '0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err_code   <= cfg_bad ? 2'b11 : 2'b00;
            words_done <= '0;
            base_lat   <= base_addr;
            cnt_lat    <= count;
          end
        end
        S_FETCH: begin
          if (s_valid) begin
            m_axi_awaddr  <= base_lat + {{(30-CNT_W){1'b0}}, words_done, 2'b00};
            m_axi_wdata   <= {16'h0, s_wdata};
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
`ifdef WSL_READBACK_VERIFY_EN
            weight        <= s_wdata;
`endif
          end
        end
        S_WRITE: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) m_axi_bready  <= 1'b1;
        end
        S_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) err_code <= 2'b01;
            else begin
`ifdef WSL_READBACK_VERIFY_EN
              m_axi_araddr  <= m_axi_awaddr;
              m_axi_arvalid <= 1'b1;
`else
              words_done    <= wd_inc[CNT_W-1:0];
`endif
            end
          end
        end
`ifdef WSL_READBACK_VERIFY_EN
        S_RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        S_RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (rd_bad) err_code   <= 2'b10;
            else        words_done <= wd_inc[CNT_W-1:0];
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader with a small AXI4-Lite slave model
// (programmable AW/W ready delays, injectable BRESP error, read-back corruption).
module tb_weight_stream_loader;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [CNT_W-1:0] count = '0;
  logic             busy, done;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] words_done;
  logic [15:0]      s_wdata = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [31:0]      awaddr, wdata, araddr, rdata;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic             arvalid, arready, rvalid, rready;
  logic [3:0]       wstrb;
  logic [1:0]       bresp, rresp;

  weight_stream_loader #(.NUM_SYNAPSES(219), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .err_code(err_code), .words_done(words_done),
    .s_wdata(s_wdata), .s_valid(s_valid), .s_ready(s_ready),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // slave knobs
  int aw_delay = 0, w_delay = 0, bresp_err_idx = -1, rd_corrupt_idx = -1;
  // slave bookkeeping
  int aw_wait, w_wait, aw_n, w_n, b_n, ar_n, done_n, hold_err, stab_err, rd_seen;
  logic [31:0] aw_log [0:15];
  logic [31:0] w_log  [0:15];
  logic [3:0]  strb_log [0:15];
  logic [31:0] last_wdata, prev_awaddr, prev_wdata;
  logic        aw_stall_d, w_stall_d, aw_hs_d, w_hs_d;
  logic [15:0] wts [0:7];

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid  && (w_wait  >= w_delay);
  assign arready = arvalid;
  assign rresp   = 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; aw_n <= 0; w_n <= 0; b_n <= 0; ar_n <= 0;
      done_n <= 0; hold_err <= 0; stab_err <= 0; rd_seen <= 0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0;
      last_wdata <= '0; prev_awaddr <= '0; prev_wdata <= '0;
      aw_stall_d <= 1'b0; w_stall_d <= 1'b0; aw_hs_d <= 1'b0; w_hs_d <= 1'b0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (awvalid && awready) begin
        if (aw_n < 16) aw_log[aw_n] <= awaddr;
        aw_n <= aw_n + 1;
      end
      if (wvalid && wready) begin
        if (w_n < 16) begin w_log[w_n] <= wdata; strb_log[w_n] <= wstrb; end
        w_n <= w_n + 1;
        last_wdata <= wdata;
      end
      // valid must stay up with stable payload until ready, and drop right after
      if ((aw_stall_d && (!awvalid || awaddr != prev_awaddr)) ||
          (w_stall_d && (!wvalid || wdata != prev_wdata))) stab_err <= stab_err + 1;
      if ((aw_hs_d && awvalid) || (w_hs_d && wvalid)) hold_err <= hold_err + 1;
      aw_stall_d <= awvalid && !awready;  prev_awaddr <= awaddr;
      w_stall_d  <= wvalid && !wready;    prev_wdata  <= wdata;
      aw_hs_d    <= awvalid && awready;
      w_hs_d     <= wvalid && wready;
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_n    <= b_n + 1;
      end else if (!bvalid && aw_n > b_n && w_n > b_n) begin
        bvalid <= 1'b1;
        bresp  <= (b_n == bresp_err_idx) ? 2'b10 : 2'b00;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
      end else if (arvalid && arready) begin
        ar_n   <= ar_n + 1;
        rvalid <= 1'b1;
        rdata  <= (ar_n == rd_corrupt_idx) ? 32'h0000BEEF : last_wdata;
      end
      if (arvalid || rready || araddr != 32'h0) rd_seen <= rd_seen + 1;
      if (done) done_n <= done_n + 1;
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0;
    aw_delay = 0; w_delay = 0; bresp_err_idx = -1; rd_corrupt_idx = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [CNT_W-1:0] c);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // feeds wts[0..n-1]; stall_at holds s_valid low 5 cycles before that index
  task automatic drive_stream(input int n, input int stall_at);
    int sent, cyc, d0, stall;
    logic hs;
    sent = 0; cyc = 0; stall = 0; d0 = done_n;
    while (sent < n && done_n == d0 && cyc < 500) begin
      if (sent == stall_at && stall < 5) begin
        s_valid = 1'b0; stall++;
      end else begin
        s_valid = 1'b1; s_wdata = wts[sent];
      end
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) sent++;
    end
    s_valid = 1'b0;
    n_cmp++;
    if (cyc >= 500) begin
      n_bad++; $display("FAIL stream_timeout: sent %0d, wanted %0d", sent, n);
    end
  endtask

  task automatic wait_done(input int d0);
    int c;
    c = 0;
    while (done_n == d0 && c < 300) begin @(posedge clk); #1; c++; end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done_n !== d0 + 1) begin
      n_bad++; $display("FAIL done_pulses: got %0d cycles of done, expected 1", done_n - d0);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({busy, done, s_ready, awvalid, wvalid, bready, arvalid, rready} !== 8'h00) begin
      n_bad++; $display("FAIL reset_ctrl: got %b, expected 00000000",
                        {busy, done, s_ready, awvalid, wvalid, bready, arvalid, rready});
    end
    n_cmp++;
    if ({err_code, words_done, awaddr, wdata, araddr} !== '0) begin
      n_bad++; $display("FAIL reset_data: err %b wd %0d aw %h wd %h ar %h, expected all 0",
                        err_code, words_done, awaddr, wdata, araddr);
    end
  endtask

  task automatic test_basic_load();
    int d0;
    apply_reset();
    wts[0] = 16'h1111; wts[1] = 16'h2222; wts[2] = 16'h3333; wts[3] = 16'h4444;
    d0 = done_n;
    do_start(32'h0, 8'd4);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b, expected 1", busy); end
    drive_stream(4, -1);
    wait_done(d0);
    n_cmp++;
    if (aw_n !== 4 || w_n !== 4) begin
      n_bad++; $display("FAIL basic_counts: aw %0d w %0d, expected 4 4", aw_n, w_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (aw_log[i] !== 32'(4 * i) || w_log[i] !== {16'h0, wts[i]} || strb_log[i] !== 4'b0011) begin
        n_bad++; $display("FAIL basic_beat%0d: addr %h data %h strb %b, expected %h %h 0011",
                          i, aw_log[i], w_log[i], strb_log[i], 32'(4 * i), {16'h0, wts[i]});
      end
    end
    n_cmp++;
    if (words_done !== 8'd4 || err_code !== 2'b00 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_status: wd %0d err %b busy %b, expected 4 00 0",
                        words_done, err_code, busy);
    end
    n_cmp++;
    if (rd_seen !== 0) begin
      n_bad++; $display("FAIL read_channel_quiet: %0d cycles of read activity, expected 0", rd_seen);
    end
  endtask

  task automatic test_config();
    int d0;
    apply_reset();
    d0 = done_n;
    do_start(32'h0, 8'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_count_done: done %b busy %b, expected 1 0", done, busy);
    end
    wait_done(d0);
    n_cmp++;
    if (err_code !== 2'b00 || aw_n !== 0) begin
      n_bad++; $display("FAIL zero_count_status: err %b aw %0d, expected 00 0", err_code, aw_n);
    end
    d0 = done_n;
    do_start(32'h0, 8'd220);
    n_cmp++;
    if (done !== 1'b1 || err_code !== 2'b11) begin
      n_bad++; $display("FAIL over_count: done %b err %b, expected 1 11", done, err_code);
    end
    wait_done(d0);
    d0 = done_n;
    do_start(32'h0000_0102, 8'd1);
    n_cmp++;
    if (done !== 1'b1 || err_code !== 2'b11) begin
      n_bad++; $display("FAIL misaligned: done %b err %b, expected 1 11", done, err_code);
    end
    wait_done(d0);
    n_cmp++;
    if (aw_n !== 0 || w_n !== 0 || words_done !== 8'd0) begin
      n_bad++; $display("FAIL config_no_axi: aw %0d w %0d wd %0d, expected 0 0 0", aw_n, w_n, words_done);
    end
  endtask

  task automatic test_backpressure();
    int d0;
    apply_reset();
    wts[0] = 16'hA001; wts[1] = 16'hA002; wts[2] = 16'hA003; wts[3] = 16'hA004;
    aw_delay = 0; w_delay = 3;
    d0 = done_n;
    do_start(32'h100, 8'd4);
    drive_stream(4, 2);
    wait_done(d0);
    aw_delay = 3; w_delay = 0;
    d0 = done_n;
    do_start(32'h200, 8'd4);
    drive_stream(4, -1);
    wait_done(d0);
    n_cmp++;
    if (aw_n !== 8 || w_n !== 8) begin
      n_bad++; $display("FAIL bp_counts: aw %0d w %0d, expected 8 8", aw_n, w_n);
    end
    n_cmp++;
    if (stab_err !== 0 || hold_err !== 0) begin
      n_bad++; $display("FAIL bp_valid_hold: early-drop %0d late-drop %0d, expected 0 0", stab_err, hold_err);
    end
    n_cmp++;
    if (aw_log[3] !== 32'h10C || aw_log[7] !== 32'h20C || w_log[6] !== 32'h0000A003) begin
      n_bad++; $display("FAIL bp_beats: %h %h %h, expected 0000010c 0000020c 0000a003",
                        aw_log[3], aw_log[7], w_log[6]);
    end
    n_cmp++;
    if (words_done !== 8'd4 || err_code !== 2'b00) begin
      n_bad++; $display("FAIL bp_status: wd %0d err %b, expected 4 00", words_done, err_code);
    end
  endtask

  task automatic test_bresp_error();
    int d0;
    apply_reset();
    for (int i = 0; i < 5; i++) wts[i] = 16'(16'h0500 + i);
    bresp_err_idx = 1;
    d0 = done_n;
    do_start(32'h0, 8'd5);
    drive_stream(5, -1);
    wait_done(d0);
    n_cmp++;
    if (err_code !== 2'b01 || words_done !== 8'd1) begin
      n_bad++; $display("FAIL bresp_status: err %b wd %0d, expected 01 1", err_code, words_done);
    end
    n_cmp++;
    if (aw_n !== 2 || awvalid !== 1'b0 || wvalid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL bresp_abort: aw %0d awv %b wv %b busy %b, expected 2 0 0 0",
                        aw_n, awvalid, wvalid, busy);
    end
  endtask

  task automatic test_reset_mid_write();
    int d0;
    apply_reset();
    wts[0] = 16'h7777; wts[1] = 16'h8888;
    aw_delay = 20;
    do_start(32'h0, 8'd4);
    drive_stream(1, -1);
    @(posedge clk); #1;
    n_cmp++;
    if (awvalid !== 1'b1) begin n_bad++; $display("FAIL midwrite_awvalid: got %b, expected 1", awvalid); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, s_ready, awvalid, wvalid, bready, err_code, words_done, awaddr, wdata} !== '0) begin
      n_bad++; $display("FAIL async_reset: busy %b awv %b wv %b awaddr %h wdata %h, expected all 0",
                        busy, awvalid, wvalid, awaddr, wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; aw_delay = 0;
    d0 = done_n;
    do_start(32'h40, 8'd2);
    drive_stream(2, -1);
    wait_done(d0);
    n_cmp++;
    if (aw_n !== 2 || aw_log[1] !== 32'h44 || w_log[1] !== 32'h00008888 || words_done !== 8'd2) begin
      n_bad++; $display("FAIL restart: aw %0d addr %h data %h wd %0d, expected 2 00000044 00008888 2",
                        aw_n, aw_log[1], w_log[1], words_done);
    end
  endtask

`ifdef WSL_READBACK_VERIFY_EN
  task automatic test_verify();
    int d0;
    apply_reset();
    wts[0] = 16'h00AA; wts[1] = 16'h00BB; wts[2] = 16'h00EF; wts[3] = 16'h00CC;
    rd_corrupt_idx = 2;
    d0 = done_n;
    do_start(32'h0, 8'd4);
    drive_stream(4, -1);
    wait_done(d0);
    n_cmp++;
    if (err_code !== 2'b10 || words_done !== 8'd2) begin
      n_bad++; $display("FAIL verify_status: err %b wd %0d, expected 10 2", err_code, words_done);
    end
    n_cmp++;
    if (aw_n !== 3 || ar_n !== 3 || arvalid !== 1'b0 || rready !== 1'b0) begin
      n_bad++; $display("FAIL verify_traffic: aw %0d ar %0d arv %b rr %b, expected 3 3 0 0",
                        aw_n, ar_n, arvalid, rready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_config();
    test_backpressure();
    test_bresp_error();
    test_reset_mid_write();
`ifdef WSL_READBACK_VERIFY_EN
    test_verify();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
